// File: rtl/maxpool_stream.sv
// Streaming max-pooling over a raster-order image, one pixel per accepted cycle.
// Build macro MAXPOOL_RELU_FUSE_EN clamps every sample to >= 0 before pooling.
module maxpool_stream #(
   parameter int I_WIDTH     = 16,
   parameter int CHANNELS    = 5,
   parameter int IMAGE_SIZE  = 15,
   parameter int FILTER_SIZE = 2,
   parameter int STRIDE      = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clk_en,
   input  logic                         in_valid,
   input  logic [CHANNELS*I_WIDTH-1:0]  in_data,
   output logic [CHANNELS*I_WIDTH-1:0]  out_data,
   output logic                         valid,
   output logic                         frame_done
);

   localparam int OUT_SIZE = IMAGE_SIZE / STRIDE;
   localparam int CW       = $clog2(IMAGE_SIZE + 1);
   localparam int IW       = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
   localparam int DW       = CHANNELS * I_WIDTH;

   localparam logic [CW-1:0] IMG_LAST = CW'(IMAGE_SIZE - 1);
   localparam logic [CW-1:0] PH_LAST  = CW'(STRIDE - 1);
   localparam logic [CW-1:0] OUT_LAST = CW'(OUT_SIZE - 1);
   localparam logic [CW-1:0] OUT_N    = CW'(OUT_SIZE);

   generate
      if (STRIDE != FILTER_SIZE || FILTER_SIZE < 2 || FILTER_SIZE > 4) begin : g_bad_cfg
         $error("maxpool_stream: STRIDE must equal FILTER_SIZE and FILTER_SIZE must be 2..4");
      end
   endgenerate

   // Raster position plus its split into window phase and window index, so no divider is needed.
   logic [CW-1:0] col_r, row_r, col_ph_r, row_ph_r, col_ix_r, row_ix_r;
   logic [DW-1:0] buf_r [0:(1<<IW)-1];
   logic [DW-1:0] out_data_r;
   logic          valid_r, frame_done_r;

   logic          accept_s, in_range_s, first_s, win_end_s, frame_end_s;
   logic [DW-1:0] entry_s, pool_s, upd_s;
   logic signed [I_WIDTH-1:0] sample_s, held_s;

   // Per-channel window maximum against the row-band buffer entry.
   always_comb begin
      accept_s    = clk_en & in_valid;
      in_range_s  = (col_ix_r < OUT_N) && (row_ix_r < OUT_N);
      first_s     = (col_ph_r == '0) && (row_ph_r == '0);
      win_end_s   = in_range_s && (col_ph_r == PH_LAST) && (row_ph_r == PH_LAST);
      frame_end_s = win_end_s && (col_ix_r == OUT_LAST) && (row_ix_r == OUT_LAST);
      entry_s     = buf_r[col_ix_r[IW-1:0]];
      pool_s      = '0;
      upd_s       = '0;
      sample_s    = '0;
      held_s      = '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
`ifdef MAXPOOL_RELU_FUSE_EN
         sample_s = in_data[ch*I_WIDTH +: I_WIDTH];
         sample_s = sample_s[I_WIDTH-1] ? '0 : sample_s;
`else
         sample_s = in_data[ch*I_WIDTH +: I_WIDTH];
`endif
         held_s = entry_s[ch*I_WIDTH +: I_WIDTH];
         pool_s[ch*I_WIDTH +: I_WIDTH] = (held_s > sample_s) ? held_s : sample_s;
         upd_s[ch*I_WIDTH +: I_WIDTH]  = first_s ? sample_s : pool_s[ch*I_WIDTH +: I_WIDTH];
      end
   end

   // Position counters; remainder pixels beyond the last full window still advance them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_r    <= '0;
         row_r    <= '0;
         col_ph_r <= '0;
         row_ph_r <= '0;
         col_ix_r <= '0;
         row_ix_r <= '0;
      end else if (accept_s) begin
         if (col_r == IMG_LAST) begin
            col_r    <= '0;
            col_ph_r <= '0;
            col_ix_r <= '0;
            if (row_r == IMG_LAST) begin
               row_r    <= '0;
               row_ph_r <= '0;
               row_ix_r <= '0;
            end else begin
               row_r <= row_r + CW'(1);
               if (row_ph_r == PH_LAST) begin
                  row_ph_r <= '0;
                  row_ix_r <= row_ix_r + CW'(1);
               end else begin
                  row_ph_r <= row_ph_r + CW'(1);
               end
            end
         end else begin
            col_r <= col_r + CW'(1);
            if (col_ph_r == PH_LAST) begin
               col_ph_r <= '0;
               col_ix_r <= col_ix_r + CW'(1);
            end else begin
               col_ph_r <= col_ph_r + CW'(1);
            end
         end
      end
   end

   // Row-band buffer is left unreset: the first pixel of every window overwrites its entry.
   always_ff @(posedge clk) begin
      if (accept_s && in_range_s) begin
         buf_r[col_ix_r[IW-1:0]] <= upd_s;
      end
   end

   // Output register: a pulse lasts one enabled cycle, data holds between pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r      <= 1'b0;
         frame_done_r <= 1'b0;
         out_data_r   <= '0;
      end else if (clk_en) begin
         valid_r      <= accept_s && win_end_s;
         frame_done_r <= accept_s && frame_end_s;
         if (accept_s && win_end_s) begin
            out_data_r <= pool_s;
         end
      end
   end

   assign out_data   = out_data_r;
   assign valid      = valid_r;
   assign frame_done = frame_done_r;

endmodule

// File: tb/tb_maxpool_stream.sv
// Self-checking bench for maxpool_stream: window maxima from a frame-level reference model.
module tb_maxpool_stream;

   localparam int W   = 16;
   localparam int CH  = 5;
   localparam int IS  = 15;
   localparam int FS  = 2;
   localparam int OS  = IS / FS;
   localparam int CH2 = 2;
   localparam int IS2 = 8;
   localparam int FS2 = 4;
   localparam int OS2 = IS2 / FS2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clk_en = 1'b0;
   logic in_valid = 1'b0;
   logic in_valid2 = 1'b0;
   logic [CH*W-1:0]  in_data = '0;
   logic [CH2*W-1:0] in_data2 = '0;
   logic [CH*W-1:0]  out_data;
   logic [CH2*W-1:0] out_data2;
   logic valid, frame_done, valid2, frame_done2;

   int total = 0;
   int bad = 0;
   int img  [IS][IS][CH];
   int img2 [IS2][IS2][CH2];

   logic [CH*W-1:0]  obs_q[$], exp_q[$];
   bit               obs_fd_q[$], exp_fd_q[$];
   logic [CH2*W-1:0] obs2_q[$], exp2_q[$];
   bit               obs2_fd_q[$], exp2_fd_q[$];
   logic en_q = 1'b0;
   logic acc_q = 1'b0;
   logic acc2_q = 1'b0;
   int lat_err = 0;
   int fd_stray = 0;

   maxpool_stream #(.I_WIDTH(W), .CHANNELS(CH), .IMAGE_SIZE(IS), .FILTER_SIZE(FS), .STRIDE(FS)) dut (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .in_valid(in_valid), .in_data(in_data),
      .out_data(out_data), .valid(valid), .frame_done(frame_done));

   maxpool_stream #(.I_WIDTH(W), .CHANNELS(CH2), .IMAGE_SIZE(IS2), .FILTER_SIZE(FS2), .STRIDE(FS2)) dut2 (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .in_valid(in_valid2), .in_data(in_data2),
      .out_data(out_data2), .valid(valid2), .frame_done(frame_done2));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      en_q   <= clk_en;
      acc_q  <= clk_en && in_valid;
      acc2_q <= clk_en && in_valid2;
   end

   // A new output is one seen after an enabled edge; held values across disabled edges are not recounted.
   always @(negedge clk) begin
      if (rst_n && en_q && valid) begin
         obs_q.push_back(out_data);
         obs_fd_q.push_back(frame_done);
         if (!acc_q) lat_err++;
      end
      if (rst_n && en_q && valid2) begin
         obs2_q.push_back(out_data2);
         obs2_fd_q.push_back(frame_done2);
         if (!acc2_q) lat_err++;
      end
      if (frame_done && !valid) fd_stray++;
   end

   function automatic int relu(input int v);
`ifdef MAXPOOL_RELU_FUSE_EN
      return (v < 0) ? 0 : v;
`else
      return v;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_obs();
      obs_q.delete(); obs_fd_q.delete(); exp_q.delete(); exp_fd_q.delete();
      obs2_q.delete(); obs2_fd_q.delete(); exp2_q.delete(); exp2_fd_q.delete();
      lat_err = 0;
      fd_stray = 0;
   endtask

   // Reference: each pooled pixel is the max over its FS x FS block of the stored frame.
   task automatic build_exp();
      logic [CH*W-1:0] e;
      for (int oy = 0; oy < OS; oy++)
         for (int ox = 0; ox < OS; ox++) begin
            for (int ch = 0; ch < CH; ch++) begin
               int m = relu(img[oy*FS][ox*FS][ch]);
               for (int dy = 0; dy < FS; dy++)
                  for (int dx = 0; dx < FS; dx++)
                     if (relu(img[oy*FS+dy][ox*FS+dx][ch]) > m) m = relu(img[oy*FS+dy][ox*FS+dx][ch]);
               e[ch*W +: W] = W'(m);
            end
            exp_q.push_back(e);
            exp_fd_q.push_back(oy == OS-1 && ox == OS-1);
         end
   endtask

   task automatic build_exp2();
      logic [CH2*W-1:0] e;
      for (int oy = 0; oy < OS2; oy++)
         for (int ox = 0; ox < OS2; ox++) begin
            for (int ch = 0; ch < CH2; ch++) begin
               int m = relu(img2[oy*FS2][ox*FS2][ch]);
               for (int dy = 0; dy < FS2; dy++)
                  for (int dx = 0; dx < FS2; dx++)
                     if (relu(img2[oy*FS2+dy][ox*FS2+dx][ch]) > m) m = relu(img2[oy*FS2+dy][ox*FS2+dx][ch]);
               e[ch*W +: W] = W'(m);
            end
            exp2_q.push_back(e);
            exp2_fd_q.push_back(oy == OS2-1 && ox == OS2-1);
         end
   endtask

   task automatic fill_ramp();
      for (int r = 0; r < IS; r++)
         for (int c = 0; c < IS; c++)
            for (int ch = 0; ch < CH; ch++) img[r][c][ch] = r*15 + c;
   endtask

   task automatic fill_random();
      for (int r = 0; r < IS; r++)
         for (int c = 0; c < IS; c++)
            for (int ch = 0; ch < CH; ch++) img[r][c][ch] = int'($urandom_range(65535)) - 32768;
   endtask

   // mode 1: an idle cycle after every pixel and a 3-cycle clk_en drop before pixel (1,5).
   task automatic drive_frame(input int mode, input int npix);
      int p = 0;
      for (int r = 0; r < IS; r++)
         for (int c = 0; c < IS; c++) begin
            if (p < npix) begin
               for (int ch = 0; ch < CH; ch++) in_data[ch*W +: W] = W'(img[r][c][ch]);
               if (mode == 1 && r == 1 && c == 5) begin
                  clk_en = 1'b0; in_valid = 1'b1;
                  repeat (3) step();
                  clk_en = 1'b1;
               end
               in_valid = 1'b1;
               step();
               if (mode == 1) begin in_valid = 1'b0; step(); end
            end
            p++;
         end
      in_valid = 1'b0;
   endtask

   task automatic drive_frame2();
      for (int r = 0; r < IS2; r++)
         for (int c = 0; c < IS2; c++) begin
            for (int ch = 0; ch < CH2; ch++) in_data2[ch*W +: W] = W'(img2[r][c][ch]);
            in_valid2 = 1'b1;
            step();
         end
      in_valid2 = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clk_en = 1'b1;
      repeat (2) step();
      total++;
      if (valid !== 1'b0 || frame_done !== 1'b0 || out_data !== '0) begin
         bad++; $display("FAIL reset_state got v=%b fd=%b d=%h want 0/0/0", valid, frame_done, out_data);
      end
      total++;
      if (valid2 !== 1'b0 || frame_done2 !== 1'b0 || out_data2 !== '0) begin
         bad++; $display("FAIL reset_state2 got v=%b fd=%b d=%h want 0/0/0", valid2, frame_done2, out_data2);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_ramp(input int mode);
      clear_obs(); fill_ramp(); build_exp();
      drive_frame(mode, IS*IS);
      repeat (3) step();
      total++;
      if (obs_q.size() !== 49) begin bad++; $display("FAIL ramp%0d_count got=%0d want=49", mode, obs_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         total++;
         if (obs_q[i] !== exp_q[i] || obs_fd_q[i] !== exp_fd_q[i]) begin
            bad++; $display("FAIL ramp%0d_px%0d got=%h/%b want=%h/%b", mode, i, obs_q[i], obs_fd_q[i], exp_q[i], exp_fd_q[i]);
         end
      end
      if (obs_q.size() == 49) begin
         total++;
         if (obs_q[0][W-1:0] !== 16'd16) begin bad++; $display("FAIL ramp%0d_first got=%0d want=16", mode, obs_q[0][W-1:0]); end
         total++;
         if (obs_q[48][W-1:0] !== 16'd208 || obs_fd_q[48] !== 1'b1) begin
            bad++; $display("FAIL ramp%0d_last got=%0d/%b want=208/1", mode, obs_q[48][W-1:0], obs_fd_q[48]);
         end
      end
      total++;
      if (lat_err !== 0 || fd_stray !== 0) begin
         bad++; $display("FAIL ramp%0d_timing got lat_err=%0d fd_stray=%0d want 0/0", mode, lat_err, fd_stray);
      end
   endtask

   task automatic test_negative();
      logic [W-1:0] want;
`ifdef MAXPOOL_RELU_FUSE_EN
      want = 16'h0000;
`else
      want = 16'hFFFB;
`endif
      clear_obs();
      for (int r = 0; r < IS; r++)
         for (int c = 0; c < IS; c++)
            for (int ch = 0; ch < CH; ch++) img[r][c][ch] = -5;
      drive_frame(0, IS*IS);
      repeat (3) step();
      total++;
      if (obs_q.size() !== 49) begin bad++; $display("FAIL neg_count got=%0d want=49", obs_q.size()); end
      for (int i = 0; i < obs_q.size(); i++)
         for (int ch = 0; ch < CH; ch++) begin
            total++;
            if (obs_q[i][ch*W +: W] !== want) begin
               bad++; $display("FAIL neg_px%0d_ch%0d got=%h want=%h", i, ch, obs_q[i][ch*W +: W], want);
            end
         end
   endtask

   task automatic test_reset_mid();
      clear_obs(); fill_ramp();
      drive_frame(0, 40);
      rst_n = 1'b0;
      #1;
      total++;
      if (valid !== 1'b0 || frame_done !== 1'b0 || out_data !== '0) begin
         bad++; $display("FAIL midreset_state got v=%b fd=%b d=%h want 0/0/0", valid, frame_done, out_data);
      end
      step();
      total++;
      if (valid !== 1'b0 || out_data !== '0) begin
         bad++; $display("FAIL midreset_hold got v=%b d=%h want 0/0", valid, out_data);
      end
      rst_n = 1'b1;
      step();
      test_ramp(0);
   endtask

   task automatic test_small();
      clear_obs();
      for (int r = 0; r < IS2; r++)
         for (int c = 0; c < IS2; c++) begin
            img2[r][c][0] = int'($urandom_range(60000)) - 30000;
            img2[r][c][1] = -img2[r][c][0];
         end
      build_exp2();
      drive_frame2();
      repeat (3) step();
      total++;
      if (obs2_q.size() !== 4) begin bad++; $display("FAIL small_count got=%0d want=4", obs2_q.size()); end
      for (int i = 0; i < exp2_q.size() && i < obs2_q.size(); i++) begin
         total++;
         if (obs2_q[i] !== exp2_q[i] || obs2_fd_q[i] !== exp2_fd_q[i]) begin
            bad++; $display("FAIL small_px%0d got=%h/%b want=%h/%b", i, obs2_q[i], obs2_fd_q[i], exp2_q[i], exp2_fd_q[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int fds = 0;
      clear_obs();
      fill_random(); build_exp();
      drive_frame(0, IS*IS);
      fill_random(); build_exp();
      drive_frame(0, IS*IS);
      repeat (3) step();
      foreach (obs_fd_q[i]) if (obs_fd_q[i]) fds++;
      total++;
      if (obs_q.size() !== 98) begin bad++; $display("FAIL b2b_count got=%0d want=98", obs_q.size()); end
      total++;
      if (fds !== 2) begin bad++; $display("FAIL b2b_frame_done got=%0d want=2", fds); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         total++;
         if (obs_q[i] !== exp_q[i] || obs_fd_q[i] !== exp_fd_q[i]) begin
            bad++; $display("FAIL b2b_px%0d got=%h/%b want=%h/%b", i, obs_q[i], obs_fd_q[i], exp_q[i], exp_fd_q[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_ramp(0);
      test_negative();
      test_ramp(1);
      test_reset_mid();
      test_small();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
